// File: rtl/biset_initiator.sv
// BiSet configuration bus initiator.
//   BiSet         : bus types (control, write data, reply) and the reply-data accessor.
//   biset_initiator
//     clk_i, rst_ni            clock, async active-low reset
//     req_valid_i/req_ready_o  request handshake; req_write_i, req_addr_i, req_wdata_i
//     rsp_valid_o/rsp_ready_i  read-response handshake; rsp_rdata_o
//     setCtrl_o, setWrite_o    registered bus control / write data (one cycle per access)
//     setReply_i               OR-combined responder replies, valid two cycles after accept
//     busy_o                   a read is in flight or buffered
package BiSet;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
  } biSetCtrl;

  typedef logic [31:0] biSetData;

  typedef struct packed {
    logic [31:0] data;
  } biSetReply;

  function automatic logic [31:0] reply_data(input biSetReply r);
    return r.data;
  endfunction
endpackage

module biset_initiator #(
  parameter int             AW        = 16,
  parameter logic [AW-1:0]  IDLE_ADDR = {AW{1'b1}},
  parameter int             RSP_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [AW-1:0]    req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rdata_o,
  output BiSet::biSetCtrl  setCtrl_o,
  output BiSet::biSetData  setWrite_o,
  input  BiSet::biSetReply setReply_i,
  output logic             busy_o
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);

  logic                       live;      // low in reset, high from the first edge after release
  logic [1:0]                 vld_pipe;  // [0] read in S1, [1] read in S2
  logic [CW-1:0]              cnt;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [RSP_DEPTH-1:0][31:0] mem;
  logic [CW:0]                used;
  logic                       accept, push, pop;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every read in flight holds a FIFO slot in reserve, so a push can never
  // find the FIFO full. Writes stall with reads to keep the channel in order.
  assign used        = {{CW{1'b0}}, vld_pipe[0]} + {{CW{1'b0}}, vld_pipe[1]} + {1'b0, cnt};
  assign req_ready_o = live && (used < (CW+1)'(RSP_DEPTH));
  assign accept      = req_valid_i && req_ready_o;
  assign push        = vld_pipe[1];
  assign rsp_valid_o = (cnt != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rsp_rdata_o = rsp_valid_o ? mem[rd_ptr] : '0;
  assign busy_o      = (vld_pipe != 2'b00) || (cnt != '0);

  // Bus drive stage: one cycle per access, back to idle otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      live           <= 1'b0;
      vld_pipe       <= '0;
      setCtrl_o.addr <= 32'(IDLE_ADDR);
      setCtrl_o.we   <= 1'b0;
      setWrite_o     <= '0;
    end else begin
      live     <= 1'b1;
      vld_pipe <= {vld_pipe[0], accept && !req_write_i};
      if (accept) begin
        setCtrl_o.addr <= 32'(req_addr_i);
        setCtrl_o.we   <= req_write_i;
        setWrite_o     <= req_write_i ? req_wdata_i : '0;
      end else begin
        setCtrl_o.addr <= 32'(IDLE_ADDR);
        setCtrl_o.we   <= 1'b0;
        setWrite_o     <= '0;
      end
    end
  end

  // Response FIFO control.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_nxt(wr_ptr);
      if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= BiSet::reply_data(setReply_i);
  end
endmodule

// File: tb/tb_biset_initiator.sv
module tb_biset_initiator;
  import BiSet::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  biSetCtrl    ctrl;
  biSetData    wdat;
  biSetReply   reply;
  logic        busy;

  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  biset_initiator #(.AW(16), .IDLE_ADDR(16'hFFFF), .RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .setCtrl_o(ctrl), .setWrite_o(wdat), .setReply_i(reply), .busy_o(busy)
  );

  // Responder: 256 registers at 0x00..0xFF, registered address match, zero elsewhere.
  logic [31:0] regs [0:255];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) regs[i] <= 32'h0;
      regs[1] <= 32'hA; regs[2] <= 32'hB; regs[3] <= 32'hC;
      reply   <= '0;
    end else begin
      if (ctrl.we && ctrl.addr < 32'd256) regs[ctrl.addr[7:0]] <= wdat;
      reply.data <= (ctrl.addr < 32'd256) ? regs[ctrl.addr[7:0]] : 32'h0;
    end
  end

  // Popped responses, in order.
  logic [31:0] rq[$];
  int          rqi = 0;
  always @(posedge clk)
    if (rst_n && rsp_valid && rsp_ready) rq.push_back(rsp_rdata);

  // Overflow watch: a push that would exceed the FIFO.
  always @(posedge clk)
    if (rst_n && dut.push && !dut.pop && dut.cnt == DEPTH) begin
      fails++;
      $display("FAIL fifo_overflow: count %0d with push", dut.cnt);
    end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_rsp(input string name, input logic [31:0] exp);
    if (rq.size() > rqi) begin
      check(name, rq[rqi], exp);
      rqi++;
    end else check({name, "_missing"}, 32'd0, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check("issue_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Started at the negedge of cycle t+1; returns the cycle count to rsp_valid.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int lat, acc, nxt;
    logic [15:0] bp_addr[4];
    logic [31:0] bp_exp[4];

    tbl[0] = '{1'b1, 16'h0010, 32'hDEAD_BEEF, 32'h0};
    tbl[1] = '{1'b0, 16'h0010, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 16'h7777, 32'h0,         32'h0};
    tbl[3] = '{1'b0, 16'h0001, 32'h0,         32'hA};
    tbl[4] = '{1'b1, 16'h0011, 32'h55AA_55AA, 32'h0};
    tbl[5] = '{1'b0, 16'h0011, 32'h0,         32'h55AA_55AA};
    tbl[6] = '{1'b0, 16'h0000, 32'h0,         32'h0};

    // Reset state
    #12;
    check("rst_addr",  ctrl.addr, 32'h0000_FFFF);
    check("rst_we",    {31'd0, ctrl.we}, 32'd0);
    check("rst_wdata", wdat, 32'd0);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Isolated accesses
    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].w, tbl[i].a, tbl[i].d);
      req_valid = 1'b0;
      check($sformatf("v%0d_addr", i), ctrl.addr, {16'h0, tbl[i].a});
      check($sformatf("v%0d_we", i), {31'd0, ctrl.we}, {31'd0, tbl[i].w});
      check($sformatf("v%0d_wdata", i), wdat, tbl[i].w ? tbl[i].d : 32'h0);
      if (!tbl[i].w) begin
        wait_rsp(lat);
        check($sformatf("v%0d_lat", i), lat, 3);
      end else begin
        @(negedge clk);
        check($sformatf("v%0d_we_drop", i), {31'd0, ctrl.we}, 32'd0);
        check($sformatf("v%0d_idle_addr", i), ctrl.addr, 32'h0000_FFFF);
      end
      idle(3);
      if (!tbl[i].w) next_rsp($sformatf("v%0d_data", i), tbl[i].exp);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
    end

    // Write then read back-to-back
    issue(1'b1, 16'h0004, 32'h1234_5678);
    check("wr_we", {31'd0, ctrl.we}, 32'd1);
    issue(1'b0, 16'h0004, 32'h0);
    req_valid = 1'b0;
    check("wr_we_one_cycle", {31'd0, ctrl.we}, 32'd0);
    check("rd_addr", ctrl.addr, 32'h4);
    wait_rsp(lat);
    check("wr_rd_lat", lat, 3);
    check("wr_rd_data_live", rsp_rdata, 32'h1234_5678);
    idle(3);
    next_rsp("wr_rd_data", 32'h1234_5678);

    // Streaming reads
    issue(1'b0, 16'h0001, 32'h0);
    issue(1'b0, 16'h0002, 32'h0);
    issue(1'b0, 16'h0003, 32'h0);
    idle(8);
    next_rsp("stream0", 32'hA);
    next_rsp("stream1", 32'hB);
    next_rsp("stream2", 32'hC);
    check("stream_busy", {31'd0, busy}, 32'd0);

    // Backpressure
    bp_addr = '{16'h0001, 16'h0002, 16'h0003, 16'h0010};
    bp_exp  = '{32'hA, 32'hB, 32'hC, 32'hDEAD_BEEF};
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = bp_addr[0];
    for (int c = 0; c < 12; c++) begin
      nxt = (req_valid && req_ready) ? 1 : 0;
      @(negedge clk);
      if (nxt == 1) begin
        acc++;
        if (acc < 4) req_addr = bp_addr[acc]; else req_valid = 1'b0;
      end
    end
    check("bp_accepts", acc, 2);
    check("bp_ready_low", {31'd0, req_ready}, 32'd0);
    check("bp_valid", {31'd0, rsp_valid}, 32'd1);
    check("bp_head", rsp_rdata, 32'hA);
    check("bp_no_pops", rq.size() - rqi, 0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && acc < 4; c++) begin
      nxt = (req_valid && req_ready) ? 1 : 0;
      @(negedge clk);
      if (nxt == 1) begin
        acc++;
        if (acc < 4) req_addr = bp_addr[acc]; else req_valid = 1'b0;
      end
    end
    check("bp_all_accepted", acc, 4);
    idle(8);
    for (int i = 0; i < 4; i++) next_rsp($sformatf("bp%0d", i), bp_exp[i]);

    // Reset mid-operation
    issue(1'b0, 16'h0001, 32'h0);
    issue(1'b0, 16'h0002, 32'h0);
    req_valid = 1'b0;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_addr", ctrl.addr, 32'h0000_FFFF);
    check("mid_we", {31'd0, ctrl.we}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle(6);
    check("mid_no_rsp", rq.size() - rqi, 0);
    check("mid_busy_after", {31'd0, busy}, 32'd0);
    issue(1'b0, 16'h0003, 32'h0);
    req_valid = 1'b0;
    wait_rsp(lat);
    check("post_rst_lat", lat, 3);
    idle(3);
    next_rsp("post_rst_data", 32'hC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
